// File: rtl/pcs_rx_sync.sv
// pcs_rx_sync: 1000BASE-X receive code-group synchronization (comma lock, parity, error level)
// Ports: GTX_CLK clock; mr_main_reset sync active-high reset; PUDI[9:0] received code-group (bit 9 = a);
//        code_sync_status high while synchronized; rx_even parity of SUDI; SUDI[9:0] registered PUDI;
//        SUDI_valid SUDI holds a code-group consumed since reset;
//        sync_loss_cnt[7:0] saturating sync-loss count, present only with PCS_SYNC_LOSS_CNT_EN.
module pcs_rx_sync #(
  parameter int GOOD_CGS_MAX = 4,
  parameter int ERR_LVL_MAX = 4
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic [9:0] PUDI,
  output logic       code_sync_status,
  output logic       rx_even,
  output logic [9:0] SUDI,
  output logic       SUDI_valid
`ifdef PCS_SYNC_LOSS_CNT_EN
  ,
  output logic [7:0] sync_loss_cnt
`endif
);
  localparam int LW = $clog2(ERR_LVL_MAX + 1);
  localparam int GW = $clog2(GOOD_CGS_MAX + 1);
  // RD- forms of the 5b/6b (abcdei) and 3b/4b (fghj) sub-blocks; RD+ forms are derived by complement
  localparam logic [5:0] SIX_N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] FOUR_D [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                        4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] FOUR_K [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                                        4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [7:0] K_X7 [4] = '{8'hF7, 8'hFB, 8'hFD, 8'hFE};
  function automatic logic [9:0] enc(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s;
    logic [3:0] f;
    logic rd1, a7;
    x = b[4:0];
    y = b[7:5];
    s = (k && x == 5'd28) ? 6'b001111 : SIX_N[x];
    rd1 = ($countones(s) == 3) ? rd : ~rd;
    s = (rd && ($countones(s) != 3 || x == 5'd7)) ? ~s : s;
    // alternate D.x.7 avoids a run of five equal bits across the sub-block boundary
    a7 = rd1 ? (x == 5'd11 || x == 5'd13 || x == 5'd14) : (x == 5'd17 || x == 5'd18 || x == 5'd20);
    f = k ? FOUR_K[y] : (y == 3'd7 && a7) ? 4'b0111 : FOUR_D[y];
    f = (rd1 && (k || $countones(f) != 2 || y == 3'd3)) ? ~f : f;
    return {s, f};
  endfunction
  function automatic logic [1023:0] build_mask(input logic konly);
    logic [1023:0] m;
    m = '0;
    for (int r = 0; r < 2; r++) begin
      if (!konly)
        for (int b = 0; b < 256; b++) m[enc(8'(b), 1'b0, 1'(r))] = 1'b1;
      for (int y = 0; y < 8; y++) m[enc({3'(y), 5'd28}, 1'b1, 1'(r))] = 1'b1;
      for (int i = 0; i < 4; i++) m[enc(K_X7[i], 1'b1, 1'(r))] = 1'b1;
    end
    return m;
  endfunction
  localparam logic [1023:0] K_MASK = build_mask(1'b1);
  localparam logic [1023:0] VALID_MASK = build_mask(1'b0);
  typedef enum logic [2:0] {
    LOSS_OF_SYNC, COMMA_DETECT_1, ACQUIRE_SYNC_1, COMMA_DETECT_2,
    ACQUIRE_SYNC_2, COMMA_DETECT_3, SYNC_ACQUIRED
  } state_t;
  state_t state, state_n;
  logic [LW-1:0] lvl, lvl_n;
  logic [GW-1:0] good_cgs, good_n;
  logic comma, valid, data, cgbad, last_good;
  always_comb begin
    comma = PUDI[9:3] == 7'b0011111 || PUDI[9:3] == 7'b1100000;
    valid = VALID_MASK[PUDI];
    data = valid && !K_MASK[PUDI];
    // a comma must land on an even code-group; rx_even still describes the previous one
    cgbad = !valid || (comma && rx_even);
    last_good = good_cgs == GW'(GOOD_CGS_MAX - 1);
    state_n = state;
    lvl_n = '0;
    good_n = '0;
    case (state)
      LOSS_OF_SYNC:   state_n = comma ? COMMA_DETECT_1 : LOSS_OF_SYNC;
      COMMA_DETECT_1: state_n = data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1: state_n = cgbad ? LOSS_OF_SYNC : comma ? COMMA_DETECT_2 : ACQUIRE_SYNC_1;
      COMMA_DETECT_2: state_n = data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_2: state_n = cgbad ? LOSS_OF_SYNC : comma ? COMMA_DETECT_3 : ACQUIRE_SYNC_2;
      COMMA_DETECT_3: state_n = data ? SYNC_ACQUIRED : LOSS_OF_SYNC;
      SYNC_ACQUIRED: begin
        state_n = (cgbad && lvl == LW'(ERR_LVL_MAX - 1)) ? LOSS_OF_SYNC : SYNC_ACQUIRED;
        good_n = (cgbad || lvl == '0 || last_good) ? '0 : good_cgs + 1'b1;
        lvl_n = (state_n == LOSS_OF_SYNC) ? '0 : cgbad ? lvl + 1'b1 :
                (lvl != '0 && last_good) ? lvl - 1'b1 : lvl;
      end
      default: state_n = LOSS_OF_SYNC;
    endcase
  end
  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset) begin
      state <= LOSS_OF_SYNC;
      lvl <= '0;
      good_cgs <= '0;
      rx_even <= 1'b0;
      SUDI <= '0;
      SUDI_valid <= 1'b0;
    end else begin
      state <= state_n;
      lvl <= lvl_n;
      good_cgs <= good_n;
      rx_even <= (state_n == COMMA_DETECT_1 || state_n == COMMA_DETECT_2 ||
                  state_n == COMMA_DETECT_3) ? 1'b1 : ~rx_even;
      SUDI <= PUDI;
      SUDI_valid <= 1'b1;
    end
  end
  assign code_sync_status = state == SYNC_ACQUIRED;
`ifdef PCS_SYNC_LOSS_CNT_EN
  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset) sync_loss_cnt <= '0;
    else if (state == SYNC_ACQUIRED && state_n == LOSS_OF_SYNC && sync_loss_cnt != 8'hFF)
      sync_loss_cnt <= sync_loss_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_pcs_rx_sync.sv
// tb_pcs_rx_sync: scoreboard bench for pcs_rx_sync against a stage-counting reference model
module tb_pcs_rx_sync;
  localparam int GMAX = 4;
  localparam int EMAX = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] pudi = '0;
  logic sync, even_o, sudi_valid;
  logic [9:0] sudi;
`ifdef PCS_SYNC_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif
  always #5 clk = ~clk;
  pcs_rx_sync #(.GOOD_CGS_MAX(GMAX), .ERR_LVL_MAX(EMAX)) dut (
    .GTX_CLK(clk), .mr_main_reset(rst), .PUDI(pudi), .code_sync_status(sync),
    .rx_even(even_o), .SUDI(sudi), .SUDI_valid(sudi_valid)
`ifdef PCS_SYNC_LOSS_CNT_EN
    , .sync_loss_cnt(loss_cnt)
`endif
  );
  // known code-groups from the 8b/10b table (abcdei fghj)
  logic [9:0] commas [4] = '{10'b0011111010, 10'b1100000101, 10'b0011111001, 10'b0011111000};
  logic [9:0] datas [7] = '{10'b0110110101, 10'b1001000101, 10'b1010101010, 10'b0101010101,
                            10'b1001110100, 10'b1100011100, 10'b1000110111};
  logic [9:0] kother [2] = '{10'b0011110100, 10'b1110101000};
  logic [9:0] bads [5] = '{10'b0000000000, 10'b1111111111, 10'b1111100000,
                           10'b0011111111, 10'b1000111110};
  typedef struct {
    logic [9:0] sudi;
    bit vld, even, sync;
    int lvl, loss;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  int stage = 0, lvl = 0, good = 0, loss = 0;
  bit m_even = 0;
  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endfunction
  function automatic void classify(input logic [9:0] c, output bit v, output bit k);
    v = 0;
    k = 0;
    foreach (commas[i]) if (c == commas[i]) begin v = 1; k = 1; end
    foreach (kother[i]) if (c == kother[i]) begin v = 1; k = 1; end
    foreach (datas[i]) if (c == datas[i]) v = 1;
  endfunction
  // stage: 0 unsynced, 1/3/5 just saw a comma, 2/4 waiting for next comma, 6 synchronized
  task automatic step(input logic [9:0] code, input bit r);
    bit v, k, comma, bad;
    exp_t e;
    @(negedge clk);
    pudi = code;
    rst = r;
    if (r) begin
      stage = 0; lvl = 0; good = 0; loss = 0; m_even = 0;
      e.sudi = '0; e.vld = 0;
    end else begin
      classify(code, v, k);
      comma = code[9:3] == 7'b0011111 || code[9:3] == 7'b1100000;
      bad = !v || (comma && m_even);
      if (stage == 0) stage = comma ? 1 : 0;
      else if (stage % 2 == 1) stage = (v && !k) ? stage + 1 : 0;
      else if (stage < 6) stage = bad ? 0 : comma ? stage + 1 : stage;
      else if (bad) begin
        lvl++;
        good = 0;
        if (lvl == EMAX) begin
          stage = 0;
          if (loss < 255) loss++;
        end
      end else if (lvl > 0) begin
        good++;
        if (good == GMAX) begin lvl--; good = 0; end
      end
      if (stage != 6) begin lvl = 0; good = 0; end
      m_even = (stage % 2 == 1) ? 1'b1 : !m_even;
      e.sudi = code;
      e.vld = 1;
    end
    e.even = m_even;
    e.sync = stage == 6;
    e.lvl = lvl;
    e.loss = loss;
    q.push_back(e);
  endtask
  task automatic acq3();
    repeat (3) begin step(commas[0], 0); step(datas[0], 0); end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("SUDI_valid", int'(sudi_valid), int'(e.vld));
      chk("code_sync_status", int'(sync), int'(e.sync));
      chk("rx_even", int'(even_o), int'(e.even));
      chk("lvl", int'(dut.lvl), e.lvl);
      if (e.vld) chk("SUDI", int'(sudi), int'(e.sudi));
`ifdef PCS_SYNC_LOSS_CNT_EN
      chk("sync_loss_cnt", int'(loss_cnt), e.loss);
`endif
    end
  end
  initial begin
    repeat (2) step(10'($urandom), 1);
    repeat (4) begin step(commas[0], 0); step(datas[0], 0); end
    step(commas[0], 0); step(datas[0], 0); step(datas[1], 0); step(commas[0], 0);
    repeat (4) step(datas[2], 0);
    repeat (3) begin step(commas[1], 0); step(datas[3], 0); end
    repeat (4) step(bads[0], 0);
    acq3();
    step(datas[4], 0);
    step(commas[0], 0); step(datas[0], 0); step(commas[0], 0); step(datas[0], 0);
    step(commas[0], 1);
    step(commas[0], 0); step(datas[0], 0); step(commas[0], 0); step(datas[0], 0); step(commas[0], 0);
    step(datas[0], 0); step(datas[6], 0);
    step(bads[3], 0); step(datas[0], 0); step(bads[4], 0);
    acq3();
    step(kother[0], 0); step(kother[1], 0);
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 0) step(10'($urandom), 1);
      else if (r < 8) step(bads[$urandom_range(0, 4)], 0);
      else if (r < 11) step(kother[$urandom_range(0, 1)], 0);
      else if (r < 40 && (!m_even || r < 14)) step(commas[$urandom_range(0, 3)], 0);
      else step(datas[$urandom_range(0, 6)], 0);
    end
`ifdef PCS_SYNC_LOSS_CNT_EN
    step(bads[0], 1);
    for (int i = 0; i < 300; i++) begin
      acq3();
      repeat (4) step(bads[0], 0);
      if (i == 2) begin
        @(posedge clk);
        #2;
        chk("loss_cnt_after_3", int'(loss_cnt), 3);
      end
    end
    @(posedge clk);
    #2;
    chk("loss_cnt_saturated", int'(loss_cnt), 255);
`endif
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
